// File: rtl/shift_mix.sv
// shift_mix: AES round stage applying (Inv)ShiftRows then (Inv)MixColumns, with
// the column mix bypassed on the final round. Latency is 1 + MID_REG clocks.
module shift_mix #(
  parameter int MID_REG = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [127:0] state_i,
  input  logic         inv_i,
  input  logic         last_i,
  input  logic [3:0]   round_i,
  output logic         valid_o,
  output logic [127:0] state_o,
  output logic         last_o,
  output logic [3:0]   round_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n sits at [127-8n -: 8]; element s[r][c] is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] res;
    int src;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        res[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w, input logic inv);
    logic [7:0] a0, a1, a2, a3, u, v, t;
    {a0, a1, a2, a3} = w;
    // Inverse mix = forward mix after a {05 00 04 00} circulant pre-multiply.
    u = xtime(xtime(a0 ^ a2));
    v = xtime(xtime(a1 ^ a3));
    if (inv) begin
      a0 = a0 ^ u;
      a1 = a1 ^ v;
      a2 = a2 ^ u;
      a3 = a3 ^ v;
    end
    t = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1),
            a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3),
            a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s, input logic inv);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      res[127-32*c -: 32] = mix_col(s[127-32*c -: 32], inv);
    end
    return res;
  endfunction

  logic [127:0] sr_state;
  logic         cm_valid;
  logic         cm_inv;
  logic         cm_last;
  logic [127:0] cm_state;
  logic [3:0]   cm_round;

  assign sr_state = shift_rows(state_i, inv_i);

  generate
    if (MID_REG != 0) begin : g_mid
      logic         mid_valid_q;
      logic         mid_inv_q;
      logic         mid_last_q;
      logic [127:0] mid_state_q;
      logic [3:0]   mid_round_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mid_valid_q <= 1'b0;
          mid_inv_q   <= 1'b0;
          mid_last_q  <= 1'b0;
          mid_state_q <= '0;
          mid_round_q <= '0;
        end else begin
          mid_valid_q <= valid_i;
          if (valid_i) begin
            mid_inv_q   <= inv_i;
            mid_last_q  <= last_i;
            mid_state_q <= sr_state;
            mid_round_q <= round_i;
          end
        end
      end

      assign cm_valid = mid_valid_q;
      assign cm_inv   = mid_inv_q;
      assign cm_last  = mid_last_q;
      assign cm_state = mid_state_q;
      assign cm_round = mid_round_q;
    end else begin : g_direct
      assign cm_valid = valid_i;
      assign cm_inv   = inv_i;
      assign cm_last  = last_i;
      assign cm_state = sr_state;
      assign cm_round = round_i;
    end
  endgenerate

  logic [127:0] state_d;
  logic         valid_q;
  logic [127:0] state_q;
  logic         last_q;
  logic [3:0]   round_q;

  always_comb begin
    state_d = cm_state;
    if (!cm_last) begin
      state_d = mix_state(cm_state, cm_inv);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      state_q <= '0;
      last_q  <= 1'b0;
      round_q <= '0;
    end else begin
      valid_q <= cm_valid;
      if (cm_valid) begin
        state_q <= state_d;
        last_q  <= cm_last;
        round_q <= cm_round;
      end
    end
  end

  assign valid_o = valid_q;
  assign state_o = state_q;
  assign last_o  = last_q;
  assign round_o = round_q;

endmodule
